// File: rtl/int_seq_pkg.sv
// Shared constants and state encoding for the interrupt / RTI sequencer.
package int_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned FLAG_W = 4;

  localparam logic [DATA_W-1:0] DEF_VEC_ADDR = 16'h0002;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DRAIN   = 4'd1,
    PUSH_F  = 4'd2,
    PUSH_L  = 4'd3,
    PUSH_H  = 4'd4,
    VEC_L   = 4'd5,
    VEC_H   = 4'd6,
    LOAD    = 4'd7,
    POP_H   = 4'd8,
    POP_L   = 4'd9,
    POP_F   = 4'd10,
    RESTORE = 4'd11
  } state_t;

endpackage

// File: rtl/int_sequencer.sv
// Interrupt entry / RTI exit sequencer: drains the pipe, pushes or pops the
// flags+PC frame on the data-memory stack and loads the handler or return PC.
module int_sequencer
  import int_seq_pkg::*;
#(
  parameter logic [DATA_W-1:0] VEC_ADDR = DEF_VEC_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_req,
  input  logic              rti,
  input  logic              pipe_busy,
  input  logic [PC_W-1:0]   pc,
  input  logic [FLAG_W-1:0] flags,
  input  logic [DATA_W-1:0] sp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_fetch,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              sp_dec,
  output logic              sp_inc,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_next,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_out,
  output logic              int_ack,
  output logic              in_isr
);

  state_t              state;
  state_t              stateNext;
  logic [DATA_W-1:0]   spQ;
  logic [PC_W-1:0]     pcQ;
  logic [FLAG_W-1:0]   flQ;
  logic [DATA_W-1:0]   vecLo;
  logic [DATA_W-1:0]   popHi;
  logic [DATA_W-1:0]   popLo;
  logic                inIsr;

  // State register and frame/vector capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      spQ   <= '0;
      pcQ   <= '0;
      flQ   <= '0;
      vecLo <= '0;
      popHi <= '0;
      popLo <= '0;
      inIsr <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE:    if (rti && inIsr) spQ <= sp;
        DRAIN: begin
          if (!pipe_busy) begin
            spQ <= sp;
            pcQ <= pc;
            flQ <= flags;
          end
        end
        VEC_H:   vecLo <= mem_rdata;
        POP_L:   popHi <= mem_rdata;
        POP_F:   popLo <= mem_rdata;
        LOAD:    inIsr <= 1'b1;
        RESTORE: inIsr <= 1'b0;
        default: ;
      endcase
    end
  end

  // Next-state logic; in_isr alone decides which request IDLE honours.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (int_req && !inIsr)  stateNext = DRAIN;
        else if (rti && inIsr)  stateNext = POP_H;
      end
      DRAIN:   if (!pipe_busy) stateNext = PUSH_F;
      PUSH_F:  stateNext = PUSH_L;
      PUSH_L:  stateNext = PUSH_H;
      PUSH_H:  stateNext = VEC_L;
      VEC_L:   stateNext = VEC_H;
      VEC_H:   stateNext = LOAD;
      LOAD:    stateNext = IDLE;
      POP_H:   stateNext = POP_L;
      POP_L:   stateNext = POP_F;
      POP_F:   stateNext = RESTORE;
      RESTORE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Moore output decode; only LOAD/RESTORE pass mem_rdata straight through.
  always_comb begin
    stall_fetch = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    sp_dec      = 1'b0;
    sp_inc      = 1'b0;
    pc_load     = 1'b0;
    pc_next     = '0;
    flags_load  = 1'b0;
    flags_out   = '0;
    int_ack     = 1'b0;
    case (state)
      DRAIN: stall_fetch = 1'b1;
      PUSH_F, PUSH_L, PUSH_H: begin
        stall_fetch = 1'b1;
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        sp_dec      = 1'b1;
        if (state == PUSH_F) begin
          mem_addr  = spQ;
          mem_wdata = {{(DATA_W-FLAG_W){1'b0}}, flQ};
        end else if (state == PUSH_L) begin
          mem_addr  = spQ - DATA_W'(1);
          mem_wdata = pcQ[DATA_W-1:0];
        end else begin
          mem_addr  = spQ - DATA_W'(2);
          mem_wdata = pcQ[PC_W-1:DATA_W];
        end
      end
      VEC_L, VEC_H: begin
        stall_fetch = 1'b1;
        mem_req     = 1'b1;
        mem_addr    = (state == VEC_L) ? VEC_ADDR : VEC_ADDR + DATA_W'(1);
      end
      LOAD: begin
        stall_fetch = 1'b1;
        pc_load     = 1'b1;
        int_ack     = 1'b1;
        pc_next     = {mem_rdata, vecLo};
      end
      POP_H, POP_L, POP_F: begin
        stall_fetch = 1'b1;
        mem_req     = 1'b1;
        sp_inc      = 1'b1;
        if (state == POP_H)      mem_addr = spQ + DATA_W'(1);
        else if (state == POP_L) mem_addr = spQ + DATA_W'(2);
        else                     mem_addr = spQ + DATA_W'(3);
      end
      RESTORE: begin
        stall_fetch = 1'b1;
        pc_load     = 1'b1;
        pc_next     = {popHi, popLo};
        flags_load  = 1'b1;
        flags_out   = mem_rdata[FLAG_W-1:0];
      end
      default: ;
    endcase
  end

  assign in_isr = inIsr;

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: transaction-level reference model with per-cycle
// output comparison, directed scenarios with literal expectations, then random.
module tb_int_sequencer;

  localparam logic [15:0] VEC = 16'h0002;

  logic        clk = 1'b0;
  logic        rst, int_req, rti, pipe_busy;
  logic [31:0] pc;
  logic [3:0]  flags;
  logic [15:0] sp;
  logic [15:0] memRdata;
  logic        stall_fetch, mem_req, mem_we, sp_dec, sp_inc;
  logic [15:0] mem_addr, mem_wdata;
  logic        pc_load, flags_load, int_ack, in_isr;
  logic [31:0] pc_next;
  logic [3:0]  flags_out;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;
  int decCount = 0;
  int incCount = 0;

  int_sequencer #(.VEC_ADDR(VEC)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .rti(rti), .pipe_busy(pipe_busy),
    .pc(pc), .flags(flags), .sp(sp), .mem_rdata(memRdata),
    .stall_fetch(stall_fetch), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .sp_dec(sp_dec), .sp_inc(sp_inc),
    .pc_load(pc_load), .pc_next(pc_next), .flags_load(flags_load),
    .flags_out(flags_out), .int_ack(int_ack), .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT: synchronous write, one-cycle read latency.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    memRdata <= (mem_req && !mem_we) ? mem[mem_addr] : 16'($urandom);
    if (mem_req && mem_we) mem[mem_addr] = mem_wdata;
  end

  always @(negedge clk) begin
    if (sp_dec) decCount++;
    if (sp_inc) incCount++;
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        stall, req, we;
    logic [15:0] addr, wdata;
    logic        dec, inc, pcLoad;
    logic [31:0] pcNext;
    logic        flLoad;
    logic [3:0]  flOut;
    logic        ack;
    int          kind;   // 0 plain, 1 vector load, 2 frame restore
  } expT;

  logic [15:0] refMem [0:65535];
  expT         q[$];
  expT         cur;
  bit          draining = 1'b0;
  bit          mIsr = 1'b0;
  logic [15:0] popSp;

  function automatic expT mk(input logic st, rq, we, input logic [15:0] ad, wd,
                             input logic dc, ic, input int kind);
    expT e;
    e.stall = st; e.req = rq; e.we = we; e.addr = ad; e.wdata = wd;
    e.dec = dc; e.inc = ic; e.pcLoad = 1'b0; e.pcNext = '0;
    e.flLoad = 1'b0; e.flOut = '0; e.ack = 1'b0; e.kind = kind;
    return e;
  endfunction

  function automatic expT pick(input expT e);
    expT r;
    logic [15:0] fw;
    r = e;
    if (e.kind == 1) begin
      r.pcLoad = 1'b1;
      r.ack    = 1'b1;
      r.pcNext = {refMem[16'(VEC + 16'd1)], refMem[VEC]};
    end else if (e.kind == 2) begin
      fw       = refMem[16'(popSp + 16'd3)];
      r.pcLoad = 1'b1;
      r.flLoad = 1'b1;
      r.pcNext = {refMem[16'(popSp + 16'd1)], refMem[16'(popSp + 16'd2)]};
      r.flOut  = fw[3:0];
    end
    return r;
  endfunction

  task automatic buildPush(input logic [15:0] s, input logic [31:0] p, input logic [3:0] f);
    q.push_back(mk(1, 1, 1, s, 16'(f), 1, 0, 0));
    q.push_back(mk(1, 1, 1, 16'(s - 16'd1), p[15:0], 1, 0, 0));
    q.push_back(mk(1, 1, 1, 16'(s - 16'd2), p[31:16], 1, 0, 0));
    q.push_back(mk(1, 1, 0, VEC, 16'h0, 0, 0, 0));
    q.push_back(mk(1, 1, 0, 16'(VEC + 16'd1), 16'h0, 0, 0, 0));
    q.push_back(mk(1, 0, 0, 16'h0, 16'h0, 0, 0, 1));
  endtask

  task automatic buildPop(input logic [15:0] s);
    popSp = s;
    for (int k = 1; k <= 3; k++) q.push_back(mk(1, 1, 0, 16'(s + 16'(k)), 16'h0, 0, 1, 0));
    q.push_back(mk(1, 0, 0, 16'h0, 16'h0, 0, 0, 2));
  endtask

  // Each edge: retire the cycle just ended, then choose the next cycle's outputs.
  always @(posedge clk) begin : model
    expT done;
    done = cur;
    if (done.req && done.we) refMem[done.addr] = done.wdata;
    if (done.ack)    mIsr = 1'b1;
    if (done.flLoad) mIsr = 1'b0;
    if (rst) begin
      q.delete();
      draining = 1'b0;
      mIsr = 1'b0;
      cur = mk(0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    end else if (done.ack || done.flLoad) begin
      cur = mk(0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    end else if (q.size() > 0) begin
      cur = pick(q.pop_front());
    end else if (draining) begin
      if (!pipe_busy) begin
        draining = 1'b0;
        buildPush(sp, pc, flags);
        cur = pick(q.pop_front());
      end else begin
        cur = mk(1, 0, 0, 16'h0, 16'h0, 0, 0, 0);
      end
    end else if (int_req && !mIsr) begin
      draining = 1'b1;
      cur = mk(1, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    end else if (rti && mIsr) begin
      buildPop(sp);
      cur = pick(q.pop_front());
    end else begin
      cur = mk(0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    end
  end

  function automatic logic [79:0] packV(input logic st, rq, we, input logic [15:0] ad, wd,
                                        input logic dc, ic, pl, input logic [31:0] pn,
                                        input logic fl, input logic [3:0] fo, input logic ak, is);
    return 80'({st, rq, we, rq ? ad : 16'h0, (rq && we) ? wd : 16'h0, dc, ic, pl,
                pl ? pn : 32'h0, fl, fl ? fo : 4'h0, ak, is});
  endfunction

  always @(negedge clk) begin
    if (checkEn)
      chk("cycle_outputs",
          packV(stall_fetch, mem_req, mem_we, mem_addr, mem_wdata, sp_dec, sp_inc,
                pc_load, pc_next, flags_load, flags_out, int_ack, in_isr),
          packV(cur.stall, cur.req, cur.we, cur.addr, cur.wdata, cur.dec, cur.inc,
                cur.pcLoad, cur.pcNext, cur.flLoad, cur.flOut, cur.ack, mIsr));
  end

  // ---------------- stimulus ----------------
  task automatic waitLoad(input int maxc, output int n);
    @(posedge clk);
    #1 rti = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pc_load && n < maxc);
  endtask

  initial begin
    int n, d0, i0;
    logic [15:0] v;
    rst = 1'b1; int_req = 1'b0; rti = 1'b0; pipe_busy = 1'b0;
    sp = '0; pc = '0; flags = '0;
    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      mem[i] = v;
      refMem[i] = v;
    end
    mem[2] = 16'h0100; refMem[2] = 16'h0100;
    mem[3] = 16'h0000; refMem[3] = 16'h0000;

    @(posedge clk);
    #1 checkEn = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 80'({stall_fetch, mem_req, mem_we, mem_addr, mem_wdata, sp_dec,
        sp_inc, pc_load, pc_next, flags_load, flags_out, int_ack, in_isr}), 80'h0);

    // Basic interrupt
    d0 = decCount;
    @(posedge clk);
    #1 sp = 16'h07FF; pc = 32'h0001_0040; flags = 4'b0101; int_req = 1'b1;
    waitLoad(20, n);
    chk("basic_latency", 80'(n), 80'd7);
    chk("basic_vector", 80'({pc_next, int_ack}), 80'({32'h0000_0100, 1'b1}));
    @(negedge clk);
    chk("basic_in_isr", 80'(in_isr), 80'd1);
    chk("basic_frame", 80'({mem[16'h07FF], mem[16'h07FE], mem[16'h07FD]}), 80'h0005_0040_0001);
    chk("basic_sp_dec", 80'(decCount - d0), 80'd3);

    // int_req blocked while in handler
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("int_blocked", 80'(stall_fetch), 80'd0);
    end
    @(posedge clk);
    #1 int_req = 1'b0;

    // RTI
    i0 = incCount;
    @(posedge clk);
    #1 sp = 16'h07FC; rti = 1'b1;
    waitLoad(20, n);
    chk("rti_latency", 80'(n), 80'd4);
    chk("rti_restore", 80'({pc_next, flags_out, flags_load}), 80'({32'h0001_0040, 4'b0101, 1'b1}));
    @(negedge clk);
    chk("rti_in_isr", 80'(in_isr), 80'd0);
    chk("rti_sp_inc", 80'(incCount - i0), 80'd3);

    // RTI outside a handler is ignored
    @(posedge clk);
    #1 rti = 1'b1;
    @(posedge clk);
    #1 rti = 1'b0;
    @(negedge clk);
    chk("rti_ignored", 80'({stall_fetch, in_isr}), 80'h0);

    // Drain: pipe_busy held for 4 cycles after acceptance
    @(posedge clk);
    #1 sp = 16'h07FF; pc = 32'h0001_0040; flags = 4'b0101; pipe_busy = 1'b1; int_req = 1'b1;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 pipe_busy = 1'b0;
      end
    join_none
    waitLoad(30, n);
    chk("drain_latency", 80'(n), 80'd11);
    @(posedge clk);
    #1 int_req = 1'b0; sp = 16'h07FC; rti = 1'b1;
    waitLoad(20, n);
    chk("drain_rti_pc", 80'(pc_next), 80'h0001_0040);

    // Stack wrap through address zero
    @(posedge clk);
    #1 sp = 16'h0001; pc = 32'hABCD_1234; flags = 4'hA; int_req = 1'b1;
    waitLoad(20, n);
    chk("wrap_latency", 80'(n), 80'd7);
    @(posedge clk);
    #1 int_req = 1'b0;
    @(negedge clk);
    chk("wrap_frame", 80'({mem[16'h0001], mem[16'h0000], mem[16'hFFFF]}), 80'h000A_1234_ABCD);
    @(posedge clk);
    #1 sp = 16'hFFFE; rti = 1'b1;
    waitLoad(20, n);
    chk("wrap_rti", 80'({pc_next, flags_out}), 80'({32'hABCD_1234, 4'hA}));

    // Reset during PUSH_L abandons the frame
    @(posedge clk);
    mem[16'h00FE] = 16'hBEEF; refMem[16'h00FE] = 16'hBEEF;
    #1 sp = 16'h0100; pc = 32'h5555_6666; flags = 4'h3; int_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; int_req = 1'b0;
    @(negedge clk);
    chk("rst_in_push_l", 80'({mem_req, mem_we, mem_addr}), 80'({1'b1, 1'b1, 16'h00FF}));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_outputs", 80'({stall_fetch, mem_req, mem_we, sp_dec, sp_inc, pc_load,
        flags_load, int_ack, in_isr, pc_next, flags_out}), 80'h0);
    repeat (3) @(negedge clk);
    chk("rst_no_push_h", 80'({mem[16'h00FE], mem[16'h00FF]}), 80'h0000_BEEF_6666);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 399) == 0);
      int_req   = ($urandom_range(0, 3) == 0);
      rti       = ($urandom_range(0, 5) == 0);
      pipe_busy = ($urandom_range(0, 2) == 0);
      sp        = 16'($urandom);
      pc        = $urandom;
      flags     = 4'($urandom);
    end
    @(posedge clk);
    #1 rst = 1'b0; int_req = 1'b0; rti = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
